// File: rtl/chunked_adder.sv
// Multi-cycle adder: adds CHUNK bits per clock, LSB chunk first, with a valid/ready handshake.
// Optional subtract port enabled by defining CHUNKED_ADDER_SUB_EN.
module chunked_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef CHUNKED_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned N  = WIDTH / CHUNK;
  localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] KLast = KW'(N - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e           state_q;
  logic [KW-1:0]    k_q;
  logic [WIDTH-1:0] a_q, b_q, acc_q, sum_q;
  logic             carry_q, cout_q, in_ready_q, out_valid_q;

  logic [CHUNK:0]   chunk_sum;
  logic [WIDTH-1:0] acc_d;

  always_comb begin
    chunk_sum = {1'b0, a_q[k_q*CHUNK +: CHUNK]} + {1'b0, b_q[k_q*CHUNK +: CHUNK]}
              + {{CHUNK{1'b0}}, carry_q};
    acc_d = acc_q;
    acc_d[k_q*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      k_q         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q        <= a;
            k_q        <= '0;
            acc_q      <= '0;
`ifdef CHUNKED_ADDER_SUB_EN
            // Subtraction as a + ~b + 1; cin is ignored in that mode.
            b_q        <= sub ? ~b : b;
            carry_q    <= sub ? 1'b1 : cin;
`else
            b_q        <= b;
            carry_q    <= cin;
`endif
            in_ready_q <= 1'b0;
            state_q    <= StCalc;
          end
        end
        StCalc: begin
          acc_q   <= acc_d;
          carry_q <= chunk_sum[CHUNK];
          k_q     <= k_q + 1'b1;
          if (k_q == KLast) begin
            sum_q       <= acc_d;
            cout_q      <= chunk_sum[CHUNK];
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= StIdle;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_chunked_adder.sv
// Scoreboard bench for chunked_adder: 16/4 instance for the main checks, 8/8 instance for the
// single-chunk case. Subtract cases run when CHUNKED_ADDER_SUB_EN is defined.
module tb_chunked_adder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, cin, out_valid, out_ready, cout;
  logic [15:0] a, b, sum;
`ifdef CHUNKED_ADDER_SUB_EN
  logic        sub;
  logic        sub8;
`endif

  logic       in_valid8, in_ready8, cin8, out_valid8, out_ready8, cout8;
  logic [7:0] a8, b8, sum8;

  chunked_adder #(.WIDTH(16), .CHUNK(4)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef CHUNKED_ADDER_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  chunked_adder #(.WIDTH(8), .CHUNK(8)) u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .a         (a8),
    .b         (b8),
    .cin       (cin8),
`ifdef CHUNKED_ADDER_SUB_EN
    .sub       (sub8),
`endif
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .sum       (sum8),
    .cout      (cout8)
  );

  int total = 0;
  int bad   = 0;
  logic [16:0] sb_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare every retired 16-bit result against the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) check("sb_result", {15'd0, cout, sum}, {15'd0, sb_q.pop_front()});
    end
  end

  function automatic logic [16:0] model(input logic [15:0] ia, input logic [15:0] ib,
                                        input logic icin, input logic isub);
    if (isub) return {1'b0, ia} + {1'b0, ~ib} + 17'd1;
    return {1'b0, ia} + {1'b0, ib} + {16'd0, icin};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!in_ready && n < 40) begin
      step();
      n++;
    end
    check(tag, 32'(n < 40), 32'd1);
  endtask

  task automatic run_op(input logic [15:0] ia, input logic [15:0] ib, input logic icin,
                        input logic isub, input int stall);
    int          n;
    logic [15:0] s0;
    logic        c0;
    a = ia; b = ib; cin = icin; in_valid = 1'b1; out_ready = 1'b0;
`ifdef CHUNKED_ADDER_SUB_EN
    sub = isub;
`endif
    wait_ready("accept_wait");
    sb_q.push_back(model(ia, ib, icin, isub));
    step();
    // Scramble operands after accept; the result must not depend on them.
    in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
`ifdef CHUNKED_ADDER_SUB_EN
    sub = 1'($urandom);
`endif
    n = 0;
    while (!out_valid && n < 40) begin
      step();
      n++;
    end
    check("latency", 32'(n), 32'd4);
    s0 = sum;
    c0 = cout;
    repeat (stall) begin
      step();
      check("hold_sum", {16'd0, sum}, {16'd0, s0});
      check("hold_cout", {31'd0, cout}, {31'd0, c0});
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("busy_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("retire_valid", {31'd0, out_valid}, 32'd0);
    check("retire_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint t_last;
    longint t_now;
    int     n;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b0;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; out_ready8 = 1'b0;
`ifdef CHUNKED_ADDER_SUB_EN
    sub = 1'b0; sub8 = 1'b0;
`endif
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #10;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_sum", {16'd0, sum}, 32'd0);
    check("rst_cout", {31'd0, cout}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    step();

    // Full carry ripple across every chunk boundary.
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
    // Long backpressure.
    run_op(16'h1234, 16'h4321, 1'b1, 1'b0, 10);
    run_op(16'h8000, 16'h8000, 1'b1, 1'b0, 1);
    run_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 2);

    // Reset after two CALC edges must drop the operation.
    a = 16'hABCD; b = 16'h1111; cin = 1'b1; in_valid = 1'b1;
    wait_ready("rst_test_wait");
    step();
    in_valid = 1'b0;
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_sum", {16'd0, sum}, 32'd0);
    #3 rst_n = 1'b1;
    out_ready = 1'b0;
    repeat (6) begin
      step();
      check("no_stale_valid", {31'd0, out_valid}, 32'd0);
    end
    check("ready_after_rst", {31'd0, in_ready}, 32'd1);
    run_op(16'h0003, 16'h0004, 1'b0, 1'b0, 0);

`ifdef CHUNKED_ADDER_SUB_EN
    run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 0);
    run_op(16'h0007, 16'h0005, 1'b0, 1'b1, 1);
    run_op(16'h1234, 16'h0034, 1'b1, 1'b0, 0);
`endif

    // Single-chunk instance: one CALC edge.
    check("w8_ready", {31'd0, in_ready8}, 32'd1);
    a8 = 8'h80; b8 = 8'h80; cin8 = 1'b1; in_valid8 = 1'b1;
    step();
    in_valid8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
    check("w8_calc_valid", {31'd0, out_valid8}, 32'd0);
    step();
    check("w8_valid", {31'd0, out_valid8}, 32'd1);
    check("w8_sum", {24'd0, sum8}, 32'h01);
    check("w8_cout", {31'd0, cout8}, 32'd1);
    out_ready8 = 1'b1;
    step();
    out_ready8 = 1'b0;
    check("w8_retire", {31'd0, out_valid8}, 32'd0);

    // Back-to-back stream with in_valid held high.
    out_ready = 1'b1;
    t_last = 0;
    for (int i = 0; i < 8; i++) begin
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); in_valid = 1'b1;
      wait_ready("stream_wait");
      sb_q.push_back(model(a, b, cin, 1'b0));
      @(posedge clk);
      t_now = longint'($time);
      if (i > 0) check("stream_period", 32'((t_now - t_last) / 10), 32'd6);
      t_last = t_now;
      #1;
    end
    in_valid = 1'b0;
    n = 0;
    while (sb_q.size() != 0 && n < 40) begin
      step();
      n++;
    end
    out_ready = 1'b0;
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
